// File: rtl/csa_mul_iter.sv
// Iterative carry-save multiplier: K multiplier bits per ACCUM cycle into a redundant
// sum/carry pair, then one carry-propagate add with sign fix-up.
//   state   | meaning
//   IDLE    | waiting for an operation, in_ready=1
//   ACCUM   | N carry-save accumulation cycles
//   RESOLVE | sum+carry, negate if needed, select half
//   DONE    | result held with out_valid until accepted
module csa_mul_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter int TAG_WIDTH      = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [TAG_WIDTH-1:0] out_tag
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESOLVE, S_DONE} state_t;
  state_t state_q, state_d;

  logic [1:0]           op_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 neg_q;
  logic [PW-1:0]        mcand_q, sum_q, carry_q;
  logic [WIDTH-1:0]     mplier_q, result_q;
  logic [CW-1:0]        cnt_q;

  logic                 a_sgn, b_sgn, last_iter;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [PW-1:0]        csa_s, csa_c, pp, prod, prod_fix;

  // MUL is treated as MULH: the low half does not depend on signedness
  assign a_sgn     = (in_op != 2'b11) & in_a[WIDTH-1];
  assign b_sgn     = ~in_op[1] & in_b[WIDTH-1];
  assign a_mag     = a_sgn ? -in_a : in_a;
  assign b_mag     = b_sgn ? -in_b : in_b;
  assign last_iter = (cnt_q == CW'(N - 1));

  always_comb begin
    csa_s = sum_q;
    csa_c = carry_q;
    pp    = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      pp = mplier_q[j] ? (mcand_q << j) : '0;
      {csa_c, csa_s} = {((csa_s & csa_c) | (csa_s & pp) | (csa_c & pp)) << 1,
                        csa_s ^ csa_c ^ pp};
    end
  end

  assign prod     = sum_q + carry_q;
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_valid) state_d = S_ACCUM;
      S_ACCUM:   if (last_iter) state_d = S_RESOLVE;
      S_RESOLVE: state_d = S_DONE;
      S_DONE:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (clear_in) state_d = S_IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)      state_q <= S_IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      op_q     <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (rdy_in && !clear_in) begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q     <= in_op;
          tag_q    <= in_tag;
          neg_q    <= a_sgn ^ b_sgn;
          mcand_q  <= {{WIDTH{1'b0}}, a_mag};
          mplier_q <= b_mag;
          sum_q    <= '0;
          carry_q  <= '0;
          cnt_q    <= '0;
        end
        S_ACCUM: begin
          sum_q    <= csa_s;
          carry_q  <= csa_c;
          mcand_q  <= mcand_q << BITS_PER_CYCLE;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          cnt_q    <= cnt_q + CW'(1);
        end
        S_RESOLVE:
          result_q <= (op_q == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[PW-1:WIDTH];
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = result_q;
  assign out_tag    = tag_q;
endmodule

// File: doc/csa_mul_iter.md
# csa_mul_iter

Iterative, parametrised multiplier for the M-extension execution path. Each cycle it retires BITS_PER_CYCLE multiplier bits into a redundant sum/carry accumulator through a chain of 3:2 carry-save stages, then does one carry-propagate add with sign fix-up. It accepts one operation at a time over a valid/ready handshake, carries a ROB tag through, and can be flushed on misprediction.

## Interface
- WIDTH, 32: operand width; result register width.
- BITS_PER_CYCLE, 4: multiplier bits consumed per ACCUM cycle; must satisfy WIDTH % BITS_PER_CYCLE == 0 and be ≥1.
- TAG_WIDTH, 5: width of passthrough tag.
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global enable; low freezes all state, handshakes do not complete.
- clear_in  input  1  flush; aborts any in-flight or pending operation.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept; high only in IDLE.
- in_op  input  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- in_a, in_b  input  WIDTH  rs1, rs2 (in_a is the signed side for MULHSU).
- in_tag  input  TAG_WIDTH  ROB tag.
- out_valid  output  1  result held valid until accepted.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  selected half of the 2·WIDTH product.
- out_tag  output  TAG_WIDTH  tag of the operation.

## Operation
- States: IDLE, ACCUM, RESOLVE, DONE. N = WIDTH / BITS_PER_CYCLE.
- IDLE: in_ready=1. When in_valid&rdy_in&!clear_in, latch op and tag. Latch |a| and |b| as unsigned WIDTH-bit magnitudes. A value is signed for MULH (both), MULHSU (a only) and MUL (treated as MULH; the low half is sign-agnostic). Set neg = sign(a)^sign(b) over the signed operands. Clear the sum/carry registers (2·WIDTH each) and the iteration counter. Go to ACCUM.
- ACCUM, one per cycle, N cycles:
  - Form BITS_PER_CYCLE partial products, pp_j = multiplier[j] ? multiplicand<<j : 0.
  - Reduce {sum, carry, pp_0..pp_{K-1}} to a new {sum, carry} with K cascaded 3:2 stages. All arithmetic is mod 2^(2·WIDTH); carries out of bit 2·WIDTH-1 are dropped.
  - Shift the multiplicand left by K and the multiplier right by K.
  - After the Nth cycle go to RESOLVE.
- RESOLVE: p = sum + carry, then p = neg ? -p : p (2·WIDTH two's complement). out_result = op==MUL ? p[WIDTH-1:0] : p[2·WIDTH-1:WIDTH]. Go to DONE.
- DONE: out_valid=1, out_result and out_tag stable. On out_ready&rdy_in return to IDLE. There is no same-cycle re-accept; in_ready rises the next cycle.
- Priority each edge: rst_in > !rdy_in (hold) > clear_in > normal.
- clear_in while rdy_in: go to IDLE, drop out_valid, discard any result. A handshake offered in the same cycle is not accepted.
- Reset: state IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, all internal registers 0. Reset mid-operation discards the operation.

## Timing
- Handshake at edge ending cycle T. ACCUM occupies T+1..T+N, RESOLVE T+N+1, out_valid=1 from cycle T+N+2. Defaults give out_valid in T+10.
- BITS_PER_CYCLE=WIDTH gives N=1, so out_valid in T+3.
- Each cycle with rdy_in low adds exactly one cycle of latency. Outputs hold their values while frozen.
- Throughput: one op per N+3 cycles minimum (when out_ready=1 on the first DONE cycle).
- out_valid stays asserted with constant data across any number of out_ready=0 cycles.

## Test plan
- Defaults, MUL a=7 b=0xFFFFFFFD -> out_result=0xFFFFFFEB, out_valid exactly 10 cycles after the accepting edge, tag echoed.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=b=0xFFFFFFFF -> 0xFFFFFFFF.
- Hold out_ready=0 for 5 cycles in DONE -> result and tag constant, in_ready=0. Then accept -> in_ready=1 next cycle, and back-to-back ops both correct.
- Pulse clear_in in the 4th ACCUM cycle, with in_valid high in the same cycle -> no out_valid, IDLE next cycle, that offer not accepted. The next op completes correctly.
- Drop rdy_in for 3 cycles mid-ACCUM and during DONE -> latency +3, result unchanged, no handshake completes while rdy_in=0.
- Random ops vs. a reference model for WIDTH∈{8,32} and BITS_PER_CYCLE∈{1,2,4,WIDTH}, including 0, 1, -1 and min-negative operands. Assert rst_in mid-ACCUM -> all outputs return to reset values next cycle.
